irq_trap_seq: RTL

- Parametrised interrupt arbitration and trap-entry sequencer for the multicycle core.
- Replaces the fixed two-line interrupt handling inside the core control FSM with NUM_IRQ maskable channels and fixed priority.
- Sequences mepc/mcause writes, the vector PC load, and the per-channel acknowledge handshake with timeout.
- Sits between the interrupt sources and the core control FSM / CSR file; the core FSM stalls fetch while trap_take is high.

---
 rtl/kreacher_irq_pkg.sv | 21 ++
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_trap_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/kreacher_irq_pkg.sv
// Shared definitions for the interrupt trap-entry sequencer: state encoding,
// mcause layout helpers and vector-table geometry.
package kreacher_irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_ACK     = 3'd3,
    ST_SERVICE = 3'd4
  } irq_state_e;

  localparam int DEFAULT_CAUSE_BASE = 16;
  localparam int VEC_STRIDE         = 4;

  // The interrupt flag in mcause always sits in the top bit of the register.
  function automatic int mcause_int_bit(input int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  output logic           valid,
  output logic [IDW-1:0] id
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan downwards so the lowest set index is the final assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = IDW'(i);
    end
  end

endmodule

// File: rtl/irq_trap_seq.sv
// Interrupt arbitration and trap-entry sequencer: picks the highest-priority
// enabled request, writes mepc/mcause, loads the vector PC and acknowledges.
module irq_trap_seq
  import kreacher_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int XLEN        = 64,
  parameter int VECTORED    = 1,
  parameter int CAUSE_BASE  = DEFAULT_CAUSE_BASE,
  parameter int ACK_TIMEOUT = 16,
  localparam int IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               a_reset_l,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               mie_global,
  input  logic               insn_boundary,
  input  logic               mret,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    pc_curr,
  output logic               trap_take,
  output logic               csr_mepc_we,
  output logic [XLEN-1:0]    csr_mepc_wdata,
  output logic               csr_mcause_we,
  output logic [XLEN-1:0]    csr_mcause_wdata,
  output logic               pc_load_en,
  output logic [XLEN-1:0]    pc_load_val,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_service,
  output logic [IDW-1:0]     active_id,
  output logic               ack_timeout_err
);

  localparam int CW      = $clog2(ACK_TIMEOUT + 1);
  localparam int INT_BIT = mcause_int_bit(XLEN);

  irq_state_e        state_q, state_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   vec_q, vec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [NUM_IRQ-1:0] pending;
  logic               win_vld;
  logic [IDW-1:0]     win_id;
  logic [XLEN-1:0]    vec_off;
  logic [XLEN-1:0]    cause_val;
  logic               unused_mtvec_lo;

  assign pending         = irq_req & irq_mask;
  assign unused_mtvec_lo = ^mtvec[1:0];

  irq_prio_enc #(.N(NUM_IRQ), .IDW(IDW)) u_prio (
    .req   (pending),
    .valid (win_vld),
    .id    (win_id)
  );

  always_ff @(posedge clk) begin
    if (!a_reset_l) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      pc_q    <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pc_q    <= pc_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    vec_off = (VECTORED != 0) ? XLEN'(id_q) * XLEN'(VEC_STRIDE) : '0;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    pc_d    = pc_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld && mie_global && insn_boundary) begin
          id_d    = win_id;
          pc_d    = pc_curr;
          state_d = ST_SAVE;
        end
      end
      ST_SAVE: begin
        // Vector is registered here so pc_load_val never depends on inputs.
        vec_d   = {mtvec[XLEN-1:2], 2'b00} + vec_off;
        state_d = ST_VECTOR;
      end
      ST_VECTOR: begin
        cnt_d   = '0;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (!irq_req[id_q]) begin
          state_d = ST_SERVICE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (mret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cause_val          = XLEN'(CAUSE_BASE) + XLEN'(id_q);
    cause_val[INT_BIT] = 1'b1;
  end

  always_comb begin
    trap_take        = 1'b0;
    csr_mepc_we      = 1'b0;
    csr_mepc_wdata   = '0;
    csr_mcause_we    = 1'b0;
    csr_mcause_wdata = '0;
    pc_load_en       = 1'b0;
    pc_load_val      = '0;
    irq_ack          = '0;
    in_service       = 1'b0;
    case (state_q)
      ST_SAVE: begin
        trap_take        = 1'b1;
        csr_mepc_we      = 1'b1;
        csr_mepc_wdata   = pc_q;
        csr_mcause_we    = 1'b1;
        csr_mcause_wdata = cause_val;
      end
      ST_VECTOR: begin
        trap_take   = 1'b1;
        pc_load_en  = 1'b1;
        pc_load_val = vec_q;
      end
      ST_ACK: begin
        trap_take      = 1'b1;
        irq_ack[id_q]  = 1'b1;
      end
      ST_SERVICE: in_service = 1'b1;
      default: ;
    endcase
  end

  assign active_id       = id_q;
  assign ack_timeout_err = err_q;

endmodule
